// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage
// ----------------------------------------------------------------------------
// Purpose:
//   Pipeline register between instruction decode and execute. It picks the
//   source operands with EX/MEM result bypassing, detects load-use hazards and
//   inserts a bubble for them, and honours back-pressure from EX and
//   flush/redirect. It also keeps a saturating count of load-use bubbles.
//
// Ports:
//   clk, rst_n                   clock; asynchronous active-low reset
//   i_id_valid / o_id_ready      decode handshake
//   i_id_pc, i_id_imm, i_id_op   instruction PC, immediate and opaque op code
//   i_id_rs1/rs2/rd_addr         register indices
//   i_id_rd_wen, i_id_mem_rd     instruction writes rd / is a load
//   i_rf_rd1, i_rf_rd2           register file read data for rs1/rs2
//   i_fwd_ex_*                   EX-stage result bypass
//   i_fwd_mem_*                  MEM-stage result bypass (includes load data)
//   i_flush                      redirect; kills the stage
//   i_ex_ready                   EX accepts the held instruction
//   o_ex_*                       registered instruction fields and operands
//   o_load_use_stall             a load-use bubble is inserted this cycle
//   o_bubble_cnt                 saturating count of inserted bubbles
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i_id_valid,
    output logic            o_id_ready,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic [XLEN-1:0] i_id_imm,
    input  logic [7:0]      i_id_op,
    input  logic [RA_W-1:0] i_id_rs1_addr,
    input  logic [RA_W-1:0] i_id_rs2_addr,
    input  logic [RA_W-1:0] i_id_rd_addr,
    input  logic            i_id_rd_wen,
    input  logic            i_id_mem_rd,

    input  logic [XLEN-1:0] i_rf_rd1,
    input  logic [XLEN-1:0] i_rf_rd2,

    input  logic            i_fwd_ex_wen,
    input  logic [RA_W-1:0] i_fwd_ex_addr,
    input  logic [XLEN-1:0] i_fwd_ex_data,
    input  logic            i_fwd_mem_wen,
    input  logic [RA_W-1:0] i_fwd_mem_addr,
    input  logic [XLEN-1:0] i_fwd_mem_data,

    input  logic            i_flush,
    input  logic            i_ex_ready,

    output logic            o_ex_valid,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [7:0]      o_ex_op,
    output logic [RA_W-1:0] o_ex_rd_addr,
    output logic            o_ex_rd_wen,
    output logic            o_ex_mem_rd,
    output logic [XLEN-1:0] o_ex_rs1_data,
    output logic [XLEN-1:0] o_ex_rs2_data,

    output logic            o_load_use_stall,
    output logic [31:0]     o_bubble_cnt
);

    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_pc;
    logic [XLEN-1:0] r_ex_imm;
    logic [7:0]      r_ex_op;
    logic [RA_W-1:0] r_ex_rd_addr;
    logic            r_ex_rd_wen;
    logic            r_ex_mem_rd;
    logic [XLEN-1:0] r_ex_rs1_data;
    logic [XLEN-1:0] r_ex_rs2_data;
    logic [31:0]     r_bubble_cnt;

    logic            w_load_use;
    logic            w_id_ready;
    logic            w_accept;
    logic            w_stall;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    // Operand bypass: x0 always reads zero, the younger EX result beats the
    // older MEM result, and the register file is the fallback.
    function automatic logic [XLEN-1:0] selOperand(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] rfData
    );
        if (addr == '0)
            return '0;
        else if (i_fwd_ex_wen && (i_fwd_ex_addr == addr))
            return i_fwd_ex_data;
        else if (i_fwd_mem_wen && (i_fwd_mem_addr == addr))
            return i_fwd_mem_data;
        else
            return rfData;
    endfunction

    assign w_rs1_data = selOperand(i_id_rs1_addr, i_rf_rd1);
    assign w_rs2_data = selOperand(i_id_rs2_addr, i_rf_rd2);

    // A load in EX cannot forward its data yet, so a dependent instruction in
    // decode has to wait one cycle. rs1==rs2 still counts as one hazard.
    assign w_load_use = r_ex_valid && r_ex_mem_rd && r_ex_rd_wen &&
                        (r_ex_rd_addr != '0) && i_id_valid &&
                        ((r_ex_rd_addr == i_id_rs1_addr) ||
                         (r_ex_rd_addr == i_id_rs2_addr));

    assign w_id_ready = (!r_ex_valid || i_ex_ready) && !w_load_use && !i_flush;
    assign w_accept   = i_id_valid && w_id_ready;
    assign w_stall    = w_load_use && i_ex_ready && !i_flush;

    // Stage register. Flush wins over everything, then accept. If EX drains
    // the held instruction and nothing new arrives, only the valid bit drops
    // and the data fields keep their values. Operands are forwarded only at
    // capture time, so data held under back-pressure is never re-forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_imm      <= '0;
            r_ex_op       <= '0;
            r_ex_rd_addr  <= '0;
            r_ex_rd_wen   <= 1'b0;
            r_ex_mem_rd   <= 1'b0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
        end else if (i_flush) begin
            r_ex_valid    <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid    <= 1'b1;
            r_ex_pc       <= i_id_pc;
            r_ex_imm      <= i_id_imm;
            r_ex_op       <= i_id_op;
            r_ex_rd_addr  <= i_id_rd_addr;
            r_ex_rd_wen   <= i_id_rd_wen;
            r_ex_mem_rd   <= i_id_mem_rd;
            r_ex_rs1_data <= w_rs1_data;
            r_ex_rs2_data <= w_rs2_data;
        end else if (i_ex_ready) begin
            r_ex_valid    <= 1'b0;
        end
    end

    // Bubble counter saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bubble_cnt <= '0;
        else if (w_stall && (r_bubble_cnt != 32'hFFFF_FFFF))
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end

    assign o_id_ready       = w_id_ready;
    assign o_load_use_stall = w_stall;
    assign o_ex_valid       = r_ex_valid;
    assign o_ex_pc          = r_ex_pc;
    assign o_ex_imm         = r_ex_imm;
    assign o_ex_op          = r_ex_op;
    assign o_ex_rd_addr     = r_ex_rd_addr;
    assign o_ex_rd_wen      = r_ex_rd_wen;
    assign o_ex_mem_rd      = r_ex_mem_rd;
    assign o_ex_rs1_data    = r_ex_rs1_data;
    assign o_ex_rs2_data    = r_ex_rs2_data;
    assign o_bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage
// ----------------------------------------------------------------------------
// Purpose:
//   Self-checking bench for id_ex_stage. It runs directed scenarios plus a
//   randomized run, and checks them against a reference model of the stage's
//   behaviour.
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    logic            clk;
    logic            rst_n;
    logic            idValid;
    logic            idReady;
    logic [XLEN-1:0] idPc, idImm;
    logic [7:0]      idOp;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic            rdWen, memRd;
    logic [XLEN-1:0] rf1, rf2;
    logic            exWen;
    logic [RA_W-1:0] exAddr;
    logic [XLEN-1:0] exData;
    logic            memWen;
    logic [RA_W-1:0] memAddr;
    logic [XLEN-1:0] memData;
    logic            flush, exReady;

    logic            exValid;
    logic [XLEN-1:0] exPc, exImm;
    logic [7:0]      exOp;
    logic [RA_W-1:0] exRd;
    logic            exRdWen, exMemRd;
    logic [XLEN-1:0] exRs1, exRs2;
    logic            stall;
    logic [31:0]     bubbleCnt;

    int vecCount  = 0;
    int missCount = 0;

    // Reference state: what EX should currently hold.
    bit              mValid;
    logic [XLEN-1:0] mPc, mImm, mRs1, mRs2;
    logic [7:0]      mOp;
    logic [RA_W-1:0] mRd;
    bit              mWen, mMemRd;
    longint unsigned mBcnt;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(idValid), .o_id_ready(idReady),
        .i_id_pc(idPc), .i_id_imm(idImm), .i_id_op(idOp),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_rd_addr(rd),
        .i_id_rd_wen(rdWen), .i_id_mem_rd(memRd),
        .i_rf_rd1(rf1), .i_rf_rd2(rf2),
        .i_fwd_ex_wen(exWen), .i_fwd_ex_addr(exAddr), .i_fwd_ex_data(exData),
        .i_fwd_mem_wen(memWen), .i_fwd_mem_addr(memAddr), .i_fwd_mem_data(memData),
        .i_flush(flush), .i_ex_ready(exReady),
        .o_ex_valid(exValid), .o_ex_pc(exPc), .o_ex_imm(exImm), .o_ex_op(exOp),
        .o_ex_rd_addr(exRd), .o_ex_rd_wen(exRdWen), .o_ex_mem_rd(exMemRd),
        .o_ex_rs1_data(exRs1), .o_ex_rs2_data(exRs2),
        .o_load_use_stall(stall), .o_bubble_cnt(bubbleCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // The value a source register should read, given the current bypasses.
    function automatic logic [XLEN-1:0] expOperand(input logic [RA_W-1:0] a, input logic [XLEN-1:0] rf);
        if (a == 0) return '0;
        if (exWen && exAddr == a) return exData;
        if (memWen && memAddr == a) return memData;
        return rf;
    endfunction

    task automatic resetModel();
        mValid = 0; mPc = '0; mImm = '0; mOp = '0; mRd = '0;
        mWen = 0; mMemRd = 0; mRs1 = '0; mRs2 = '0; mBcnt = 0;
    endtask

    task automatic setIdle();
        idValid = 0; idPc = '0; idImm = '0; idOp = '0;
        rs1 = '0; rs2 = '0; rd = '0; rdWen = 0; memRd = 0;
        rf1 = '0; rf2 = '0;
        exWen = 0; exAddr = '0; exData = '0;
        memWen = 0; memAddr = '0; memData = '0;
        flush = 0; exReady = 1;
    endtask

    task automatic setInstr(input logic [XLEN-1:0] pc, input logic [RA_W-1:0] a1,
                            input logic [RA_W-1:0] a2, input logic [RA_W-1:0] ad,
                            input logic wen, input logic ld);
        idValid = 1; idPc = pc; idImm = rnd64(); idOp = 8'($urandom);
        rs1 = a1; rs2 = a2; rd = ad; rdWen = wen; memRd = ld;
        rf1 = rnd64(); rf2 = rnd64();
    endtask

    // Compare every registered output against the model.
    task automatic checkOutput();
        chk("ex_valid",    {63'b0, exValid},  {63'b0, mValid});
        chk("ex_pc",       exPc,              mPc);
        chk("ex_imm",      exImm,             mImm);
        chk("ex_op",       {56'b0, exOp},     {56'b0, mOp});
        chk("ex_rd_addr",  {59'b0, exRd},     {59'b0, mRd});
        chk("ex_rd_wen",   {63'b0, exRdWen},  {63'b0, mWen});
        chk("ex_mem_rd",   {63'b0, exMemRd},  {63'b0, mMemRd});
        chk("ex_rs1_data", exRs1,             mRs1);
        chk("ex_rs2_data", exRs2,             mRs2);
        chk("bubble_cnt",  {32'b0, bubbleCnt}, mBcnt);
    endtask

    // Entered just after a falling edge with inputs driven: checks the
    // combinational handshake, advances the model across one rising edge,
    // checks registered outputs and returns at the next falling edge.
    task automatic applyStimulus();
        bit lu, rdy, st;
        #1;
        lu  = mValid && mMemRd && mWen && (mRd != 0) && idValid &&
              ((mRd == rs1) || (mRd == rs2));
        rdy = (!mValid || exReady) && !lu && !flush;
        st  = lu && exReady && !flush;
        chk("id_ready",       {63'b0, idReady}, {63'b0, rdy});
        chk("load_use_stall", {63'b0, stall},   {63'b0, st});
        if (st && mBcnt < 64'hFFFF_FFFF) mBcnt++;
        if (flush)
            mValid = 0;
        else if (idValid && rdy) begin
            mValid = 1; mPc = idPc; mImm = idImm; mOp = idOp; mRd = rd;
            mWen = rdWen; mMemRd = memRd;
            mRs1 = expOperand(rs1, rf1);
            mRs2 = expOperand(rs2, rf2);
        end else if (exReady)
            mValid = 0;
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    initial begin
        setIdle();
        resetModel();
        rst_n = 0;
        #1;
        checkOutput();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst_n = 1;

        // Bypass priority: EX beats MEM beats the register file; x0 reads 0.
        setInstr(64'h100, 5'd5, 5'd0, 5'd1, 1, 0);
        exWen = 1; exAddr = 5'd5; exData = 64'h11;
        memWen = 1; memAddr = 5'd5; memData = 64'h22;
        rf1 = 64'h33;
        applyStimulus();
        chk("fwd_ex_priority", exRs1, 64'h11);
        exWen = 0;
        idPc = 64'h104;
        applyStimulus();
        chk("fwd_mem_second", exRs1, 64'h22);
        exWen = 1; rs1 = 5'd0; idPc = 64'h108;
        applyStimulus();
        chk("fwd_x0_zero", exRs1, 64'h0);
        setIdle();

        // Load-use on rs2: one bubble, then accept with MEM-forwarded data.
        setInstr(64'h200, 5'd1, 5'd2, 5'd7, 1, 1);
        applyStimulus();
        setInstr(64'h204, 5'd3, 5'd7, 5'd8, 1, 0);
        applyStimulus();
        chk("lu_bubble_valid", {63'b0, exValid}, 64'h0);
        chk("lu_bubble_cnt",   {32'b0, bubbleCnt}, 64'h1);
        memWen = 1; memAddr = 5'd7; memData = 64'hABC;
        applyStimulus();
        chk("lu_after_fwd", exRs2, 64'hABC);
        setIdle();

        // rs1==rs2 both match the load: exactly one bubble.
        setInstr(64'h300, 5'd0, 5'd0, 5'd9, 1, 1);
        applyStimulus();
        setInstr(64'h304, 5'd9, 5'd9, 5'd10, 1, 0);
        applyStimulus();
        applyStimulus();
        chk("same_src_one_bubble", {32'b0, bubbleCnt}, 64'h2);
        setIdle();

        // Back-pressure: held fields constant for three cycles, then advance.
        setInstr(64'h400, 5'd1, 5'd2, 5'd3, 1, 0);
        applyStimulus();
        setInstr(64'h404, 5'd4, 5'd5, 5'd6, 1, 0);
        exReady = 0;
        exWen = 1; exAddr = 5'd1; exData = rnd64();
        repeat (3) applyStimulus();
        chk("hold_pc", exPc, 64'h400);
        exReady = 1;
        applyStimulus();
        chk("release_pc", exPc, 64'h404);
        setIdle();

        // Flush overrides load-use and accept; counter unchanged.
        setInstr(64'h500, 5'd0, 5'd0, 5'd7, 1, 1);
        applyStimulus();
        setInstr(64'h504, 5'd7, 5'd0, 5'd2, 1, 0);
        flush = 1;
        applyStimulus();
        chk("flush_valid", {63'b0, exValid}, 64'h0);
        chk("flush_cnt",   {32'b0, bubbleCnt}, 64'h2);
        setIdle();

        // Randomized traffic with small register space to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            setInstr(rnd64(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
            idValid = ($urandom_range(0, 3) != 0);
            exWen = 1'($urandom); exAddr = 5'($urandom_range(0, 7)); exData = rnd64();
            memWen = 1'($urandom); memAddr = 5'($urandom_range(0, 7)); memData = rnd64();
            flush = ($urandom_range(0, 9) == 0);
            exReady = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end
        setIdle();
        applyStimulus();

        // Saturation: preload the counter near the top, then two more bubbles.
        force dut.r_bubble_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_bubble_cnt;
        mBcnt = 64'hFFFF_FFFE;
        setInstr(64'h600, 5'd0, 5'd0, 5'd7, 1, 1);
        applyStimulus();
        setInstr(64'h604, 5'd7, 5'd7, 5'd7, 1, 1);
        applyStimulus();
        chk("sat_reach", {32'b0, bubbleCnt}, 64'hFFFF_FFFF);
        applyStimulus();
        setInstr(64'h608, 5'd7, 5'd0, 5'd1, 1, 0);
        applyStimulus();
        chk("sat_hold", {32'b0, bubbleCnt}, 64'hFFFF_FFFF);
        setIdle();

        // Asynchronous reset mid-cycle while holding a valid instruction.
        setInstr(64'h700, 5'd1, 5'd2, 5'd3, 1, 0);
        applyStimulus();
        #2;
        rst_n = 0;
        #1;
        resetModel();
        chk("async_rst_valid", {63'b0, exValid}, 64'h0);
        chk("async_rst_pc", exPc, 64'h0);
        checkOutput();
        @(negedge clk);
        rst_n = 1;
        setInstr(64'h8000_0000, 5'd1, 5'd2, 5'd3, 1, 0);
        applyStimulus();
        chk("post_rst_pc", exPc, 64'h8000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
